// File: rtl/rvo3_cpu_core.sv
// rvo3_cpu_core: 5-stage in-order RV64I-subset core (ALU, LUI, LD, SD).
// Latency: an instruction is fetched at n and writes back at the end of n+4; a load-use stall adds 1 cycle.
// Backpressure: none external; a load-use hazard holds PC and IF/ID and bubbles EX for one cycle.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   inst_mem_addr/valid/data      fetch address (= PC), ROM enable, combinational instruction word
//   data_mem_rw/addr/valid        data access strobe, direction (1 = store) and byte address
//   data_mem_data                 bidirectional data; driven by the core only during a store
module rvo3_cpu_core (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] inst_mem_addr,
    output logic        inst_mem_valid,
    input  logic [31:0] inst_mem_data,
    output logic        data_mem_rw,
    output logic [63:0] data_mem_addr,
    output logic        data_mem_valid,
    inout  wire  [63:0] data_mem_data
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_DWORD  = 3'b011;

    // ID/EX: decoded control plus operand values read in ID.
    // An all-zero word is a bubble (no register write, no memory access).
    typedef struct packed {
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  alu_fn;    // funct3-style ALU select
        logic        alu_alt;   // SUB for fn 000, SRA for fn 101
        logic        b_imm;     // operand B is the immediate
        logic        a_zero;    // operand A is forced to 0 (LUI)
        logic [4:0]  rs1;       // 0 when the instruction has no such source
        logic [4:0]  rs2;
        logic [4:0]  rd;        // 0 when the instruction writes nothing
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
    } idex_t;

    typedef struct packed {
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [4:0]  rd;
        logic [63:0] alu;       // ALU result or effective address
        logic [63:0] st_dat;    // forwarded rs2 for stores
    } exmem_t;

    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  rd;
        logic [63:0] res;       // ALU result or load data
    } memwb_t;

    logic [63:0] pc_q, pc_d;
    logic [31:0] ifid_q, ifid_d;
    idex_t       idex_q, idex_d, id_dec;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [63:0] rf_q [32];
    logic        stall;

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    assign inst_mem_addr  = pc_q;
    assign inst_mem_valid = ~rst;

    // ------------------------------------------------------------------
    // Decode and register read
    // ------------------------------------------------------------------
    logic [6:0]  id_opc;
    logic [2:0]  id_f3;
    logic [6:0]  id_f7;
    logic [63:0] imm_i, imm_s, imm_u;
    logic        use_rs1, use_rs2;

    assign id_opc = ifid_q[6:0];
    assign id_f3  = ifid_q[14:12];
    assign id_f7  = ifid_q[31:25];
    assign imm_i  = {{52{ifid_q[31]}}, ifid_q[31:20]};
    assign imm_s  = {{52{ifid_q[31]}}, ifid_q[31:25], ifid_q[11:7]};
    assign imm_u  = {{32{ifid_q[31]}}, ifid_q[31:12], 12'h000};

    always_comb begin
        id_dec  = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opc)
            OPC_OP: begin
                // Only base-ISA funct7 encodings; anything else is a NOP.
                if (id_f7 == 7'h00 || id_f7 == 7'h20) begin
                    id_dec.reg_wr  = 1'b1;
                    id_dec.alu_fn  = id_f3;
                    id_dec.alu_alt = ifid_q[30];
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                end
            end
            OPC_OPIMM: begin
                id_dec.reg_wr  = 1'b1;
                id_dec.alu_fn  = id_f3;
                // Bit 30 selects SRAI only; for ADDI it is just an immediate bit.
                id_dec.alu_alt = (id_f3 == 3'b101) && ifid_q[30];
                id_dec.b_imm   = 1'b1;
                id_dec.imm     = imm_i;
                use_rs1        = 1'b1;
            end
            OPC_LUI: begin
                id_dec.reg_wr = 1'b1;
                id_dec.a_zero = 1'b1;
                id_dec.b_imm  = 1'b1;
                id_dec.imm    = imm_u;
            end
            OPC_LOAD: begin
                if (id_f3 == F3_DWORD) begin
                    id_dec.reg_wr = 1'b1;
                    id_dec.mem_rd = 1'b1;
                    id_dec.b_imm  = 1'b1;
                    id_dec.imm    = imm_i;
                    use_rs1       = 1'b1;
                end
            end
            OPC_STORE: begin
                if (id_f3 == F3_DWORD) begin
                    id_dec.mem_wr = 1'b1;
                    id_dec.b_imm  = 1'b1;
                    id_dec.imm    = imm_s;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
            end
            default: ;
        endcase

        // Zeroing unused register fields keeps them out of hazard and forwarding matches.
        id_dec.rs1 = use_rs1 ? ifid_q[19:15] : 5'd0;
        id_dec.rs2 = use_rs2 ? ifid_q[24:20] : 5'd0;
        id_dec.rd  = id_dec.reg_wr ? ifid_q[11:7] : 5'd0;

        // Write-first: a register being written back this cycle reads as its new value.
        if (id_dec.rs1 == 5'd0)
            id_dec.rs1_val = '0;
        else if (memwb_q.reg_wr && memwb_q.rd == id_dec.rs1)
            id_dec.rs1_val = memwb_q.res;
        else
            id_dec.rs1_val = rf_q[id_dec.rs1];

        if (id_dec.rs2 == 5'd0)
            id_dec.rs2_val = '0;
        else if (memwb_q.reg_wr && memwb_q.rd == id_dec.rs2)
            id_dec.rs2_val = memwb_q.res;
        else
            id_dec.rs2_val = rf_q[id_dec.rs2];
    end

    // Load result is not available until MEM/WB, so a consumer directly behind a load waits one cycle.
    always_comb begin
        stall = idex_q.mem_rd && (idex_q.rd != 5'd0) &&
                ((idex_q.rd == id_dec.rs1) || (idex_q.rd == id_dec.rs2));
    end

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    function automatic logic [63:0] fwd(input logic [4:0]  rs,
                                        input logic [63:0] rf_val,
                                        input exmem_t      em,
                                        input memwb_t      mw);
        if (rs == 5'd0)
            return rf_val;
        else if (em.reg_wr && !em.mem_rd && em.rd == rs)
            return em.alu;
        else if (mw.reg_wr && mw.rd == rs)
            return mw.res;
        else
            return rf_val;
    endfunction

    logic [63:0] fwd_a, fwd_b, alu_a, alu_b, alu_y;
    logic [5:0]  shamt;

    always_comb begin
        fwd_a = fwd(idex_q.rs1, idex_q.rs1_val, exmem_q, memwb_q);
        fwd_b = fwd(idex_q.rs2, idex_q.rs2_val, exmem_q, memwb_q);
        alu_a = idex_q.a_zero ? 64'd0 : fwd_a;
        alu_b = idex_q.b_imm ? idex_q.imm : fwd_b;
        shamt = alu_b[5:0];

        alu_y = '0;
        case (idex_q.alu_fn)
            3'b000: alu_y = idex_q.alu_alt ? (alu_a - alu_b) : (alu_a + alu_b);
            3'b001: alu_y = alu_a << shamt;
            3'b010: alu_y = {63'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011: alu_y = {63'd0, alu_a < alu_b};
            3'b100: alu_y = alu_a ^ alu_b;
            3'b101: begin
                // Kept as separate statements so the arithmetic shift stays signed.
                if (idex_q.alu_alt)
                    alu_y = $signed(alu_a) >>> shamt;
                else
                    alu_y = alu_a >> shamt;
            end
            3'b110: alu_y = alu_a | alu_b;
            3'b111: alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase

        exmem_d        = '0;
        exmem_d.reg_wr = idex_q.reg_wr;
        exmem_d.mem_rd = idex_q.mem_rd;
        exmem_d.mem_wr = idex_q.mem_wr;
        exmem_d.rd     = idex_q.rd;
        exmem_d.alu    = alu_y;
        exmem_d.st_dat = fwd_b;
    end

    // ------------------------------------------------------------------
    // Memory access
    // ------------------------------------------------------------------
    // Gated by rst so nothing reaches memory in the cycle a reset is being applied.
    assign data_mem_valid = ~rst && (exmem_q.mem_rd || exmem_q.mem_wr);
    assign data_mem_rw    = data_mem_valid && exmem_q.mem_wr;
    assign data_mem_addr  = data_mem_valid ? exmem_q.alu : 64'd0;
    assign data_mem_data  = (data_mem_valid && data_mem_rw) ? exmem_q.st_dat : 64'bz;

    always_comb begin
        memwb_d        = '0;
        memwb_d.reg_wr = exmem_q.reg_wr;
        memwb_d.rd     = exmem_q.rd;
        memwb_d.res    = exmem_q.mem_rd ? data_mem_data : exmem_q.alu;
    end

    // ------------------------------------------------------------------
    // Next state for PC and IF/ID, and the ID/EX bubble on a stall
    // ------------------------------------------------------------------
    always_comb begin
        pc_d   = stall ? pc_q : (pc_q + 64'd4);
        ifid_d = stall ? ifid_q : inst_mem_data;
        idex_d = stall ? idex_t'('0) : id_dec;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            ifid_q  <= NOP_INST;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            if (memwb_q.reg_wr && memwb_q.rd != 5'd0)
                rf_q[memwb_q.rd] <= memwb_q.res;
        end
    end

endmodule

// File: tb/tb_rvo3_cpu_core.sv
// tb_rvo3_cpu_core: directed and randomized checks of rvo3_cpu_core against an ISA-level model.
// Latency: each program runs from a reset release for a fixed cycle budget.
// Backpressure: none; ROM and data memory answer combinationally.
module tb_rvo3_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] inst_mem_addr;
    logic        inst_mem_valid;
    logic [31:0] inst_mem_data;
    logic        data_mem_rw;
    logic [63:0] data_mem_addr;
    logic        data_mem_valid;
    wire  [63:0] data_mem_data;

    always #5 clk = ~clk;

    rvo3_cpu_core dut (
        .clk            (clk),
        .rst            (rst),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_valid (inst_mem_valid),
        .inst_mem_data  (inst_mem_data),
        .data_mem_rw    (data_mem_rw),
        .data_mem_addr  (data_mem_addr),
        .data_mem_valid (data_mem_valid),
        .data_mem_data  (data_mem_data)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] rom  [256];
    logic [63:0] dmem [32];

    assign inst_mem_data = inst_mem_valid ? rom[inst_mem_addr[9:2]] : 32'h0;
    assign data_mem_data = (data_mem_valid && !data_mem_rw) ? dmem[data_mem_addr[7:3]] : 64'bz;

    // Bus monitor: logs fetches, loads and stores per cycle since the last reset release.
    int          cyc;
    logic [63:0] fetch_q[$];
    logic [63:0] st_addr_q[$], st_data_q[$];
    int          st_cyc_q[$];
    logic [63:0] ld_addr_q[$];
    int          ld_cyc_q[$];

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
        end else begin
            fetch_q.push_back(inst_mem_addr);
            if (data_mem_valid) begin
                if (data_mem_rw) begin
                    st_addr_q.push_back(data_mem_addr);
                    st_data_q.push_back(data_mem_data);
                    st_cyc_q.push_back(cyc);
                    dmem[data_mem_addr[7:3]] = data_mem_data;
                end else begin
                    ld_addr_q.push_back(data_mem_addr);
                    ld_cyc_q.push_back(cyc);
                end
            end
            cyc++;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_reset();
        rst = 1'b1;
        tick(2);
        for (int i = 0; i < 256; i++) rom[i] = NOP;
        for (int i = 0; i < 32; i++) dmem[i] = 64'd0;
    endtask

    task automatic release_reset();
        fetch_q.delete();
        st_addr_q.delete();
        st_data_q.delete();
        st_cyc_q.delete();
        ld_addr_q.delete();
        ld_cyc_q.delete();
        rst = 1'b0;
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    // ISA-level reference: executes the program sequentially, no pipeline timing.
    logic [31:0] prog [64];
    logic [63:0] mem_init [32];
    logic [63:0] exp_addr_q[$], exp_data_q[$];

    function automatic logic [63:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[5:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: r = (a < b) ? 64'd1 : 64'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> b[5:0];
                else     r = a >> b[5:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic model_run(input int n);
        logic [63:0] x [32];
        logic [63:0] m [32];
        logic [31:0] w;
        logic [63:0] a, b, ii, si, res, ea;
        logic        wr;
        for (int i = 0; i < 32; i++) begin
            x[i] = 64'd0;
            m[i] = mem_init[i];
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int k = 0; k < n; k++) begin
            w   = prog[k];
            a   = x[w[19:15]];
            b   = x[w[24:20]];
            ii  = {{52{w[31]}}, w[31:20]};
            si  = {{52{w[31]}}, w[31:25], w[11:7]};
            wr  = 1'b0;
            res = 64'd0;
            case (w[6:0])
                7'h33: if (w[31:25] == 7'h00 || w[31:25] == 7'h20) begin
                    wr = 1'b1; res = alu_ref(w[14:12], w[30], a, b);
                end
                7'h13: begin
                    wr = 1'b1; res = alu_ref(w[14:12], (w[14:12] == 3'd5) && w[30], a, ii);
                end
                7'h37: begin
                    wr = 1'b1; res = {{32{w[31]}}, w[31:12], 12'h000};
                end
                7'h03: if (w[14:12] == 3'd3) begin
                    ea = a + ii; wr = 1'b1; res = m[ea[7:3]];
                end
                7'h23: if (w[14:12] == 3'd3) begin
                    ea = a + si; m[ea[7:3]] = b;
                    exp_addr_q.push_back(ea);
                    exp_data_q.push_back(b);
                end
                default: ;
            endcase
            if (wr && w[11:7] != 5'd0) x[w[11:7]] = res;
        end
    endtask

    initial begin
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [5:0]  sh;
        int          n;

        // ---- Reset and reset release ----
        begin_reset();
        @(negedge clk);
        chk("rst_inst_valid", {63'd0, inst_mem_valid}, 64'd0);
        chk("rst_dmem_valid", {63'd0, data_mem_valid}, 64'd0);
        chk("rst_dmem_rw",    {63'd0, data_mem_rw},    64'd0);
        chk("rst_dmem_addr",  data_mem_addr,           64'd0);
        tick(8);
        release_reset();
        @(negedge clk);
        chk("rel_inst_valid", {63'd0, inst_mem_valid}, 64'd1);
        chk("rel_inst_addr0", inst_mem_addr,           64'd0);
        tick(6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rel_fetch%0d", i), (fetch_q.size() > i) ? fetch_q[i] : 64'hDEAD, 64'(4 * i));
        chk("rel_no_access", 64'(st_addr_q.size() + ld_addr_q.size()), 64'd0);

        // ---- Back-to-back forwarding ----
        begin_reset();
        rom[0] = 32'h00500093;
        rom[1] = 32'h00700113;
        rom[2] = 32'h002081B3;
        rom[3] = 32'h00303023;
        release_reset();
        tick(12);
        chk("fwd_st_count", 64'(st_addr_q.size()), 64'd1);
        if (st_addr_q.size() > 0) begin
            chk("fwd_st_addr", st_addr_q[0],     64'd0);
            chk("fwd_st_data", st_data_q[0],     64'd12);
            chk("fwd_st_cyc",  64'(st_cyc_q[0]), 64'd6);
        end

        // ---- SUB / SRA sign handling ----
        begin_reset();
        rom[0] = enc_i(12'hFF8, 5'd0, 3'd0, 5'd1, 7'h13);
        rom[1] = enc_i(12'h401, 5'd1, 3'd5, 5'd2, 7'h13);
        rom[2] = enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd3, 7'h33);
        rom[3] = enc_s(12'd8,  5'd2, 5'd0);
        rom[4] = enc_s(12'd16, 5'd3, 5'd0);
        release_reset();
        tick(14);
        chk("sra_st_count", 64'(st_addr_q.size()), 64'd2);
        if (st_addr_q.size() > 1) begin
            chk("sra_addr0", st_addr_q[0], 64'd8);
            chk("sra_data0", st_data_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("sub_addr1", st_addr_q[1], 64'd16);
            chk("sub_data1", st_data_q[1], 64'd4);
        end

        // ---- Load-use stall ----
        begin_reset();
        dmem[4] = 64'h10;
        rom[0] = enc_i(12'd32, 5'd0, 3'd3, 5'd5, 7'h03);
        rom[1] = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6, 7'h33);
        rom[2] = enc_s(12'd40, 5'd6, 5'd0);
        release_reset();
        tick(14);
        chk("lu_ld_count", 64'(ld_addr_q.size()), 64'd1);
        if (ld_addr_q.size() > 0) begin
            chk("lu_ld_addr", ld_addr_q[0],     64'd32);
            chk("lu_ld_cyc",  64'(ld_cyc_q[0]), 64'd3);
        end
        chk("lu_fetch1", fetch_q[1], 64'd4);
        chk("lu_fetch2", fetch_q[2], 64'd8);
        chk("lu_fetch3", fetch_q[3], 64'd8);
        chk("lu_fetch4", fetch_q[4], 64'd12);
        chk("lu_st_count", 64'(st_addr_q.size()), 64'd1);
        if (st_addr_q.size() > 0) begin
            chk("lu_st_addr", st_addr_q[0],     64'd40);
            chk("lu_st_data", st_data_q[0],     64'h20);
            chk("lu_st_cyc",  64'(st_cyc_q[0]), 64'd6);
        end

        // ---- x0 and LUI ----
        begin_reset();
        rom[0] = enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13);
        rom[1] = enc_u(20'h12345, 5'd7);
        rom[2] = enc_s(12'd0, 5'd0, 5'd0);
        rom[3] = enc_s(12'd8, 5'd7, 5'd0);
        release_reset();
        tick(12);
        chk("x0_st_count", 64'(st_addr_q.size()), 64'd2);
        if (st_addr_q.size() > 1) begin
            chk("x0_data",  st_data_q[0], 64'd0);
            chk("lui_addr", st_addr_q[1], 64'd8);
            chk("lui_data", st_data_q[1], 64'h12345000);
        end

        // ---- Mid-run reset with SD in EX ----
        begin_reset();
        rom[0] = enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'h13);
        rom[2] = enc_s(12'd0, 5'd1, 5'd0);
        release_reset();
        tick(4);                       // cycle 4: SD in EX
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_dmem_valid", {63'd0, data_mem_valid}, 64'd0);
        tick(1);
        release_reset();
        @(negedge clk);
        chk("mid_restart_addr", inst_mem_addr,           64'd0);
        chk("mid_squash_valid", {63'd0, data_mem_valid}, 64'd0);
        tick(3);
        chk("mid_no_store", 64'(st_addr_q.size()), 64'd0);
        tick(6);
        chk("mid_rerun_count", 64'(st_addr_q.size()), 64'd1);
        if (st_addr_q.size() > 0) begin
            chk("mid_rerun_data", st_data_q[0],     64'd3);
            chk("mid_rerun_cyc",  64'(st_cyc_q[0]), 64'd5);
        end

        // ---- Randomized programs against the ISA model ----
        for (int t = 0; t < 6; t++) begin
            begin_reset();
            n = 0;
            for (int k = 0; k < 24; k++) begin
                rd = 5'($urandom_range(0, 7));
                r1 = 5'($urandom_range(0, 7));
                r2 = 5'($urandom_range(0, 7));
                f3 = 3'($urandom_range(0, 7));
                sh = 6'($urandom);
                case ($urandom_range(0, 9))
                    0, 1, 2: begin
                        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                        prog[n] = enc_r(f7, r2, r1, f3, rd, 7'h33);
                    end
                    3, 4, 9: begin
                        if (f3 == 3'd1)      imm = {6'd0, sh};
                        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00, sh};
                        else                 imm = 12'($urandom);
                        prog[n] = enc_i(imm, r1, f3, rd, 7'h13);
                    end
                    5: prog[n] = enc_u(20'($urandom), rd);
                    6: prog[n] = enc_i({4'd0, 5'($urandom_range(0, 31)), 3'd0}, 5'd0, 3'd3, rd, 7'h03);
                    7: prog[n] = enc_s({4'd0, 5'($urandom_range(0, 31)), 3'd0}, r2, 5'd0);
                    default: prog[n] = {25'($urandom), 7'h0B};
                endcase
                n++;
            end
            for (int j = 1; j < 8; j++) begin
                prog[n] = enc_s(12'(8 * j), 5'(j), 5'd0);
                n++;
            end
            for (int i = 0; i < 32; i++) begin
                mem_init[i] = {$urandom, $urandom};
                dmem[i]     = mem_init[i];
            end
            for (int k = 0; k < n; k++) rom[k] = prog[k];
            model_run(n);
            release_reset();
            tick(2 * n + 10);
            chk($sformatf("rnd%0d_st_count", t), 64'(st_addr_q.size()), 64'(exp_addr_q.size()));
            for (int i = 0; i < exp_addr_q.size() && i < st_addr_q.size(); i++) begin
                chk($sformatf("rnd%0d_st%0d_addr", t, i), st_addr_q[i], exp_addr_q[i]);
                chk($sformatf("rnd%0d_st%0d_data", t, i), st_data_q[i], exp_data_q[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
